// File: rtl/regfile_mp_if.sv
// Bus bundle for the multi-port register file: write ports, read ports and issue port.
// The ID/WB stages drive the master side; the register file is the slave.
interface regfile_mp_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NRD  = 2,
    parameter int NWR  = 2
);
    logic                 rdy;
    logic [NWR-1:0]       we;
    logic [NWR*AW-1:0]    waddr;
    logic [NWR*XLEN-1:0]  wdata;
    logic [NRD-1:0]       re;
    logic [NRD*AW-1:0]    raddr;
    logic [NRD*XLEN-1:0]  rdata;
    logic [NRD-1:0]       rbusy;
    logic                 iss_en;
    logic [AW-1:0]        iss_addr;

    modport master (
        output rdy, we, waddr, wdata, re, raddr, iss_en, iss_addr,
        input  rdata, rbusy
    );

    modport slave (
        input  rdy, we, waddr, wdata, re, raddr, iss_en, iss_addr,
        output rdata, rbusy
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port integer register file with per-register busy scoreboard,
// same-cycle write-to-read bypass and highest-index write-port priority.
module regfile_mp #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int NRD  = 2,
    parameter int NWR  = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_mp_if.slave  bus
);

    logic [XLEN-1:0] regs   [1:NREG-1];
    logic            busy   [1:NREG-1];
    logic            wr_hit [1:NREG-1];
    logic [XLEN-1:0] wr_val [1:NREG-1];
    logic            iss_hit[1:NREG-1];

    logic [NRD*XLEN-1:0] rdata_c;
    logic [NRD-1:0]      rbusy_c;

    // Per-register write decode; later ports overwrite earlier ones so the highest index wins.
    // Matching against every legal index keeps x0 and out-of-range addresses from ever hitting.
    always_comb begin
        for (int k = 1; k < NREG; k++) begin
            wr_hit[k]  = 1'b0;
            wr_val[k]  = '0;
            iss_hit[k] = bus.rdy && bus.iss_en && (bus.iss_addr == AW'(k));
            for (int i = 0; i < NWR; i++) begin
                if (bus.rdy && bus.we[i] && (bus.waddr[i*AW +: AW] == AW'(k))) begin
                    wr_hit[k] = 1'b1;
                    wr_val[k] = bus.wdata[i*XLEN +: XLEN];
                end
            end
        end
    end

    // Issue is applied after the write so a same-cycle issue keeps the register busy.
    always_ff @(posedge clk) begin
        for (int k = 1; k < NREG; k++) begin
            if (!rst_n) begin
                regs[k] <= '0;
                busy[k] <= 1'b0;
            end else begin
                if (wr_hit[k]) begin
                    regs[k] <= wr_val[k];
                    busy[k] <= 1'b0;
                end
                if (iss_hit[k]) begin
                    busy[k] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        rdata_c = '0;
        rbusy_c = '0;
        for (int j = 0; j < NRD; j++) begin
            if (rst_n && bus.re[j]) begin
                for (int k = 1; k < NREG; k++) begin
                    if (bus.raddr[j*AW +: AW] == AW'(k)) begin
                        rdata_c[j*XLEN +: XLEN] = wr_hit[k] ? wr_val[k] : regs[k];
                        rbusy_c[j]              = wr_hit[k] ? 1'b0 : busy[k];
                    end
                end
            end
        end
    end

    assign bus.rdata = rdata_c;
    assign bus.rbusy = rbusy_c;

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised self-checking bench for regfile_mp against an array-based model,
// plus directed scenarios with hand-computed expectations.
module tb_regfile_mp;
    localparam int XLEN = 32;
    localparam int NREG = 16;
    localparam int AW   = 5;
    localparam int NRD  = 2;
    localparam int NWR  = 2;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    logic [XLEN-1:0] m_regs [NREG];
    logic            m_busy [NREG];

    logic            rst_v;
    logic            rdy_v;
    logic            we_v   [NWR];
    logic [AW-1:0]   wa_v   [NWR];
    logic [XLEN-1:0] wd_v   [NWR];
    logic            re_v   [NRD];
    logic [AW-1:0]   ra_v   [NRD];
    logic            iss_v;
    logic [AW-1:0]   issa_v;

    regfile_mp_if #(.XLEN(XLEN), .AW(AW), .NRD(NRD), .NWR(NWR)) bus ();

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NRD(NRD), .NWR(NWR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected read of port j straight from the rules: reset/disabled/x0/out-of-range,
    // then the highest-index matching write port, then stored state.
    function automatic void modelRead(input int j, output logic [XLEN-1:0] d, output logic b);
        int a;
        a = int'(bus.raddr[j*AW +: AW]);
        d = '0;
        b = 1'b0;
        if (rst_n && bus.re[j] && a != 0 && a < NREG) begin
            d = m_regs[a];
            b = m_busy[a];
            if (bus.rdy) begin
                for (int i = 0; i < NWR; i++) begin
                    if (bus.we[i] && int'(bus.waddr[i*AW +: AW]) == a) begin
                        d = bus.wdata[i*XLEN +: XLEN];
                        b = 1'b0;
                    end
                end
            end
        end
    endfunction

    initial begin
        for (int k = 0; k < NREG; k++) begin
            m_regs[k] = '0;
            m_busy[k] = 1'b0;
        end
    end

    // Model state update on each rising edge, using the inputs presented that cycle.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NREG; k++) begin
                m_regs[k] = '0;
                m_busy[k] = 1'b0;
            end
        end else if (bus.rdy) begin
            for (int i = 0; i < NWR; i++) begin
                int a;
                a = int'(bus.waddr[i*AW +: AW]);
                if (bus.we[i] && a != 0 && a < NREG) begin
                    m_regs[a] = bus.wdata[i*XLEN +: XLEN];
                    m_busy[a] = 1'b0;
                end
            end
            if (bus.iss_en && bus.iss_addr != 0 && int'(bus.iss_addr) < NREG) begin
                m_busy[int'(bus.iss_addr)] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        for (int j = 0; j < NRD; j++) begin
            logic [XLEN-1:0] ed;
            logic            eb;
            modelRead(j, ed, eb);
            checks++;
            if (bus.rdata[j*XLEN +: XLEN] !== ed) begin
                failures++;
                $display("[TB] FAIL model_rdata port=%0d t=%0t got=%h exp=%h", j, $time, bus.rdata[j*XLEN +: XLEN], ed);
            end
            checks++;
            if (bus.rbusy[j] !== eb) begin
                failures++;
                $display("[TB] FAIL model_rbusy port=%0d t=%0t got=%b exp=%b", j, $time, bus.rbusy[j], eb);
            end
        end
    end

    task automatic packBus();
        rst_n      = rst_v;
        bus.rdy    = rdy_v;
        bus.iss_en = iss_v;
        bus.iss_addr = issa_v;
        for (int i = 0; i < NWR; i++) begin
            bus.we[i]                 = we_v[i];
            bus.waddr[i*AW +: AW]     = wa_v[i];
            bus.wdata[i*XLEN +: XLEN] = wd_v[i];
        end
        for (int j = 0; j < NRD; j++) begin
            bus.re[j]             = re_v[j];
            bus.raddr[j*AW +: AW] = ra_v[j];
        end
    endtask

    task automatic setIdle();
        rst_v  = 1'b1;
        rdy_v  = 1'b1;
        iss_v  = 1'b0;
        issa_v = '0;
        for (int i = 0; i < NWR; i++) begin
            we_v[i] = 1'b0;
            wa_v[i] = '0;
            wd_v[i] = '0;
        end
        for (int j = 0; j < NRD; j++) begin
            re_v[j] = 1'b0;
            ra_v[j] = '0;
        end
    endtask

    // Presents the staged inputs for one cycle; returns mid-cycle when outputs have settled.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        packBus();
        @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int j, input logic [XLEN-1:0] ed, input logic eb);
        checks++;
        if (bus.rdata[j*XLEN +: XLEN] !== ed || bus.rbusy[j] !== eb) begin
            failures++;
            $display("[TB] FAIL %s port=%0d got=%h/%b exp=%h/%b", name, j,
                     bus.rdata[j*XLEN +: XLEN], bus.rbusy[j], ed, eb);
        end
    endtask

    task automatic readSetup(input int a0, input int a1);
        re_v[0] = 1'b1;
        ra_v[0] = AW'(a0);
        re_v[1] = 1'b1;
        ra_v[1] = AW'(a1);
    endtask

    initial begin
        setIdle();
        rst_v = 1'b0;
        packBus();
        applyStimulus();
        readSetup(5, 6);
        applyStimulus();
        checkOutput("reset_read", 0, 32'h0, 1'b0);

        setIdle(); readSetup(5, 0);
        we_v[0] = 1'b1; wa_v[0] = 5'd5; wd_v[0] = 32'hDEADBEEF;
        applyStimulus();
        checkOutput("bypass_x5", 0, 32'hDEADBEEF, 1'b0);
        setIdle(); readSetup(5, 0);
        applyStimulus();
        checkOutput("stored_x5", 0, 32'hDEADBEEF, 1'b0);

        setIdle(); readSetup(5, 6); rst_v = 1'b0;
        we_v[0] = 1'b1; wa_v[0] = 5'd6; wd_v[0] = 32'h12345678;
        applyStimulus();
        checkOutput("in_reset_x5", 0, 32'h0, 1'b0);
        checkOutput("in_reset_x6", 1, 32'h0, 1'b0);
        setIdle(); readSetup(5, 6);
        applyStimulus();
        checkOutput("after_reset_x5", 0, 32'h0, 1'b0);
        checkOutput("after_reset_x6", 1, 32'h0, 1'b0);

        setIdle(); readSetup(0, 0);
        we_v[0] = 1'b1; wa_v[0] = 5'd0; wd_v[0] = 32'hFFFFFFFF;
        we_v[1] = 1'b1; wa_v[1] = 5'd0; wd_v[1] = 32'hFFFFFFFF;
        applyStimulus();
        checkOutput("x0_same_p0", 0, 32'h0, 1'b0);
        checkOutput("x0_same_p1", 1, 32'h0, 1'b0);
        setIdle(); readSetup(0, 0);
        applyStimulus();
        checkOutput("x0_after", 1, 32'h0, 1'b0);

        setIdle(); readSetup(20, 4);
        we_v[0] = 1'b1; wa_v[0] = 5'd20; wd_v[0] = 32'hCAFEF00D;
        applyStimulus();
        checkOutput("range_read20", 0, 32'h0, 1'b0);
        checkOutput("range_alias_x4", 1, 32'h0, 1'b0);
        setIdle(); readSetup(4, 20);
        applyStimulus();
        checkOutput("range_after_x4", 0, 32'h0, 1'b0);

        setIdle(); readSetup(7, 7);
        we_v[0] = 1'b1; wa_v[0] = 5'd7; wd_v[0] = 32'h11;
        we_v[1] = 1'b1; wa_v[1] = 5'd7; wd_v[1] = 32'h22;
        applyStimulus();
        checkOutput("conflict_bypass_p1", 1, 32'h22, 1'b0);
        checkOutput("conflict_bypass_p0", 0, 32'h22, 1'b0);
        setIdle(); readSetup(7, 7);
        applyStimulus();
        checkOutput("conflict_stored", 1, 32'h22, 1'b0);

        setIdle(); readSetup(3, 0); iss_v = 1'b1; issa_v = 5'd3;
        applyStimulus();
        checkOutput("issue_t", 0, 32'h0, 1'b0);
        setIdle(); readSetup(3, 0);
        applyStimulus();
        checkOutput("issue_t1", 0, 32'h0, 1'b1);
        applyStimulus();
        checkOutput("issue_t2", 0, 32'h0, 1'b1);
        setIdle(); readSetup(3, 0);
        we_v[1] = 1'b1; wa_v[1] = 5'd3; wd_v[1] = 32'h55;
        applyStimulus();
        checkOutput("busy_clear_t3", 0, 32'h55, 1'b0);
        setIdle(); readSetup(3, 0);
        applyStimulus();
        checkOutput("busy_clear_t4", 0, 32'h55, 1'b0);

        setIdle(); readSetup(0, 9); iss_v = 1'b1; issa_v = 5'd9;
        we_v[0] = 1'b1; wa_v[0] = 5'd9; wd_v[0] = 32'hAB;
        applyStimulus();
        checkOutput("setwins_same", 1, 32'hAB, 1'b0);
        setIdle(); readSetup(0, 9);
        applyStimulus();
        checkOutput("setwins_next", 1, 32'hAB, 1'b1);

        setIdle(); we_v[0] = 1'b1; wa_v[0] = 5'd4; wd_v[0] = 32'h44;
        applyStimulus();
        setIdle(); readSetup(4, 0); rdy_v = 1'b0;
        we_v[0] = 1'b1; wa_v[0] = 5'd4; wd_v[0] = 32'h99;
        iss_v = 1'b1; issa_v = 5'd4;
        applyStimulus();
        checkOutput("stall_same", 0, 32'h44, 1'b0);
        setIdle(); readSetup(4, 0);
        applyStimulus();
        checkOutput("stall_after", 0, 32'h44, 1'b0);

        // Random traffic with narrow address range to force conflicts, bypasses and out-of-range hits.
        for (int c = 0; c < 2000; c++) begin
            rst_v  = ($urandom_range(0, 63) != 0);
            rdy_v  = ($urandom_range(0, 7) != 0);
            iss_v  = $urandom_range(0, 1) == 1;
            issa_v = AW'($urandom_range(0, 19));
            for (int i = 0; i < NWR; i++) begin
                we_v[i] = $urandom_range(0, 1) == 1;
                wa_v[i] = AW'($urandom_range(0, 19));
                wd_v[i] = $urandom;
            end
            for (int j = 0; j < NRD; j++) begin
                re_v[j] = $urandom_range(0, 3) != 0;
                ra_v[j] = AW'($urandom_range(0, 19));
            end
            applyStimulus();
        end

        setIdle();
        applyStimulus();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
